// File: rtl/fetch_stage_if.sv
// Line-fill bus between the fetch stage (master) and instruction memory (slave).
interface fetch_stage_if;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [127:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// MIRI instruction-fetch stage: PC, 4-line x 16 B direct-mapped instruction
// cache, and a two-state miss handler that fills one line over req/ack.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_fetch,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  fetch_stage_if.master mem,
  output logic [31:0]   instruction,
  output logic [31:0]   pc_out,
  output logic          block_pipe_instr_cache
);

  typedef enum logic {RUN = 1'b0, REQ = 1'b1} state_t;

  state_t           state;
  logic [31:0]      pc;
  logic [31:4]      miss_line;   // line address of the outstanding miss
  logic [3:0]       valid;
  logic [31:6]      tag_q  [4];
  logic [3:0][31:0] data_q [4];

  logic [1:0]  idx;
  logic [1:0]  fill_idx;
  logic        hit;
  logic        fill;
  logic [31:0] hit_word;

  // Lookup: index = pc[5:4], tag = pc[31:6], word = pc[3:2].
  assign idx      = pc[5:4];
  assign hit      = valid[idx] && (tag_q[idx] == pc[31:6]);
  assign hit_word = data_q[idx][pc[3:2]];

  // A fill only happens while a request is outstanding; stray acks are ignored.
  assign fill     = (state == REQ) && mem.mem_ack;
  assign fill_idx = miss_line[5:4];

  // Only two states exist, so "RUN and miss" reduces to "not hit".
  assign block_pipe_instr_cache = (state == REQ) || !hit;

  // Address is derived from the latched miss line, so it cannot move during REQ.
  assign mem.mem_addr = {miss_line, 4'b0000};

  // Control FSM, PC and the registered instruction/pc_out outputs.
  // NOTE: every register here uses <= so all updates see pre-edge values;
  // mixing in = would make the result depend on statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= PC_RESET;
      pc_out      <= PC_RESET;
      instruction <= NOP_INSTR;
      miss_line   <= PC_RESET[31:4];
      valid       <= '0;
      mem.mem_req <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          // A miss starts a fill even when fetch is stalled or redirected.
          if (!hit) begin
            state       <= REQ;
            miss_line   <= pc[31:4];
            mem.mem_req <= 1'b1;
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            state           <= RUN;
            valid[fill_idx] <= 1'b1;
            mem.mem_req     <= 1'b0;
          end
        end
        default: begin
          state       <= RUN;
          mem.mem_req <= 1'b0;
        end
      endcase

      // Redirect beats normal fetch; a fill in flight still lands on miss_line.
      if (branch_taken) begin
        pc          <= branch_target & ~32'h3;
        instruction <= NOP_INSTR;
      end else if (en_fetch) begin
        if (block_pipe_instr_cache) begin
          instruction <= NOP_INSTR;
        end else begin
          instruction <= hit_word;
          pc_out      <= pc;
          pc          <= pc + 32'd4;
        end
      end
    end
  end

  // Tag and data arrays, written when the memory returns the line.
  // NOTE: no reset on these arrays; the valid bits alone make stale
  // contents unreachable, and leaving them unreset keeps them RAM-mappable.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= miss_line[31:6];
      data_q[fill_idx] <= mem.mem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner-case
// sequences, and randomized traffic against a line-residency reference model.
module tb_fetch_stage;

  localparam logic [31:0] PC_RESET  = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_fetch;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        block_pipe_instr_cache;

  fetch_stage_if mem ();

  fetch_stage #(.PC_RESET(PC_RESET), .NOP_INSTR(NOP_INSTR)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .en_fetch               (en_fetch),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .mem                    (mem.master),
    .instruction            (instruction),
    .pc_out                 (pc_out),
    .block_pipe_instr_cache (block_pipe_instr_cache)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Backing memory: every word is a fixed, distinct function of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5EED_0000;
  endfunction

  function automatic logic [127:0] line_data(input logic [31:0] a);
    logic [31:0] base;
    base = a & ~32'hF;
    return {mem_word(base + 32'd12), mem_word(base + 32'd8),
            mem_word(base + 32'd4), mem_word(base)};
  endfunction

  // Reference model: which memory line each of the 4 slots holds, plus
  // whether a miss is outstanding. Instruction content is read from memory.
  logic [31:0] m_pc, m_pc_out, m_instr, m_miss;
  logic [31:0] m_res [4];
  bit          m_vld [4];
  bit          m_pending;

  function automatic bit m_hit(input logic [31:0] a);
    int unsigned slot;
    slot = (a / 16) % 4;
    return m_vld[slot] && (m_res[slot] == (a & ~32'hF));
  endfunction

  function automatic bit m_block();
    return m_pending || !m_hit(m_pc);
  endfunction

  task automatic model_reset();
    m_pc = PC_RESET; m_pc_out = PC_RESET; m_instr = NOP_INSTR;
    m_pending = 0; m_miss = PC_RESET;
    for (int i = 0; i < 4; i++) m_vld[i] = 0;
  endtask

  task automatic model_step(input bit en, input bit br, input logic [31:0] tgt, input bit ack);
    bit          blk;
    bit          h;
    int unsigned slot;
    h   = m_hit(m_pc);
    blk = m_pending || !h;
    if (!m_pending) begin
      if (!h) begin
        m_pending = 1;
        m_miss    = m_pc & ~32'hF;
      end
    end else if (ack) begin
      m_pending    = 0;
      slot         = (m_miss / 16) % 4;
      m_vld[slot]  = 1;
      m_res[slot]  = m_miss;
    end
    if (br) begin
      m_pc    = tgt & ~32'h3;
      m_instr = NOP_INSTR;
    end else if (en) begin
      if (blk) m_instr = NOP_INSTR;
      else begin
        m_instr  = mem_word(m_pc);
        m_pc_out = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: drive inputs, advance the model, then compare #1 after the edge.
  task automatic cycle(input bit en, input bit br, input logic [31:0] tgt, input bit ack);
    en_fetch      = en;
    branch_taken  = br;
    branch_target = tgt;
    mem.mem_ack   = ack;
    mem.mem_rdata = line_data(mem.mem_addr);
    model_step(en, br, tgt, ack);
    @(posedge clk);
    #1;
    check("model_instr", instruction, m_instr);
    check("model_pc_out", pc_out, m_pc_out);
    check("model_block", 32'(block_pipe_instr_cache), 32'(m_block()));
    check("model_req", 32'(mem.mem_req), 32'(m_pending));
    if (m_pending) check("model_addr", mem.mem_addr, m_miss);
  endtask

  typedef struct {
    bit          en;
    bit          br;
    logic [31:0] tgt;
    bit          ack;
    logic [31:0] instr;
    logic [31:0] pc_o;
    bit          block;
    bit          req;
    logic [31:0] addr;
  } vec_t;

  vec_t vt [13];
  logic [31:0] bases [5];

  initial begin
    // Cold start, line crossing and branch-on-hit, expected values by hand.
    vt[0]  = '{1, 0, 32'h0,    0, NOP_INSTR,          32'h1000, 1, 1, 32'h1000};
    vt[1]  = '{1, 0, 32'h0,    0, NOP_INSTR,          32'h1000, 1, 1, 32'h1000};
    vt[2]  = '{1, 0, 32'h0,    0, NOP_INSTR,          32'h1000, 1, 1, 32'h1000};
    vt[3]  = '{1, 0, 32'h0,    1, NOP_INSTR,          32'h1000, 0, 0, 32'h0};
    vt[4]  = '{1, 0, 32'h0,    0, mem_word(32'h1000), 32'h1000, 0, 0, 32'h0};
    vt[5]  = '{1, 0, 32'h0,    0, mem_word(32'h1004), 32'h1004, 0, 0, 32'h0};
    vt[6]  = '{1, 0, 32'h0,    0, mem_word(32'h1008), 32'h1008, 0, 0, 32'h0};
    vt[7]  = '{1, 0, 32'h0,    0, mem_word(32'h100C), 32'h100C, 1, 0, 32'h0};
    vt[8]  = '{1, 0, 32'h0,    0, NOP_INSTR,          32'h100C, 1, 1, 32'h1010};
    vt[9]  = '{1, 0, 32'h0,    1, NOP_INSTR,          32'h100C, 0, 0, 32'h0};
    vt[10] = '{1, 0, 32'h0,    0, mem_word(32'h1010), 32'h1010, 0, 0, 32'h0};
    vt[11] = '{1, 1, 32'h1006, 0, NOP_INSTR,          32'h1010, 0, 0, 32'h0};
    vt[12] = '{1, 0, 32'h0,    0, mem_word(32'h1004), 32'h1004, 0, 0, 32'h0};
    bases[0] = 32'h0000_1000; bases[1] = 32'h0000_2000; bases[2] = 32'h0000_3000;
    bases[3] = 32'h0000_1040; bases[4] = 32'hFFFF_FFF0;

    reset = 1'b0; en_fetch = 1'b0; branch_taken = 1'b0; branch_target = '0;
    mem.mem_ack = 1'b0; mem.mem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_instr", instruction, NOP_INSTR);
    check("rst_pc_out", pc_out, PC_RESET);
    check("rst_block", 32'(block_pipe_instr_cache), 32'd1);
    check("rst_req", 32'(mem.mem_req), 32'd0);

    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].en, vt[i].br, vt[i].tgt, vt[i].ack);
      check($sformatf("vec%0d_instr", i), instruction, vt[i].instr);
      check($sformatf("vec%0d_pc_out", i), pc_out, vt[i].pc_o);
      check($sformatf("vec%0d_block", i), 32'(block_pipe_instr_cache), 32'(vt[i].block));
      check($sformatf("vec%0d_req", i), 32'(mem.mem_req), 32'(vt[i].req));
      if (vt[i].req) check($sformatf("vec%0d_addr", i), mem.mem_addr, vt[i].addr);
    end

    // Branch during REQ: the fill still lands on 0x2000, evicting 0x1000.
    cycle(0, 1, 32'h2000, 0);
    cycle(1, 0, 32'h0, 0);
    check("br_req_addr0", mem.mem_addr, 32'h2000);
    cycle(1, 1, 32'h1000, 0);
    check("br_req_addr1", mem.mem_addr, 32'h2000);
    cycle(1, 0, 32'h0, 0);
    check("br_req_addr2", mem.mem_addr, 32'h2000);
    cycle(1, 0, 32'h0, 1);
    check("br_req_evicted", 32'(block_pipe_instr_cache), 32'd1);
    cycle(1, 0, 32'h0, 0);
    check("br_req_refetch", mem.mem_addr, 32'h1000);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 0);
    check("br_req_word", instruction, mem_word(32'h1000));

    // Stall on a hit stream: outputs frozen, then resume without skip or repeat.
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 32'h0, 0);
      check("stall_instr", instruction, mem_word(32'h1000));
      check("stall_pc_out", pc_out, 32'h1000);
    end
    cycle(1, 0, 32'h0, 0);
    check("resume_pc_out0", pc_out, 32'h1004);
    cycle(1, 0, 32'h0, 0);
    check("resume_instr1", instruction, mem_word(32'h1008));

    // Reset in the middle of a fill.
    cycle(0, 1, 32'h3000, 0);
    cycle(1, 0, 32'h0, 0);
    check("midfill_req", 32'(mem.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("midfill_rst_req", 32'(mem.mem_req), 32'd0);
    check("midfill_rst_pc_out", pc_out, PC_RESET);
    check("midfill_rst_block", 32'(block_pipe_instr_cache), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 0, 32'h0, 0);
    check("midfill_refetch", mem.mem_addr, 32'h1000);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 0);
    check("midfill_word", instruction, mem_word(32'h1000));

    // PC wrap from 0xFFFF_FFFC to 0; target low bits are dropped.
    cycle(0, 1, 32'hFFFF_FFFE, 0);
    cycle(1, 0, 32'h0, 0);
    check("wrap_addr", mem.mem_addr, 32'hFFFF_FFF0);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 0);
    check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
    check("wrap_instr", instruction, mem_word(32'hFFFF_FFFC));
    cycle(1, 0, 32'h0, 0);
    check("wrap_zero_addr", mem.mem_addr, 32'h0);
    cycle(1, 0, 32'h0, 1);
    cycle(1, 0, 32'h0, 0);
    check("wrap_zero_pc_out", pc_out, 32'h0);

    // Randomized traffic, including acks while no request is pending.
    for (int i = 0; i < 3000; i++) begin
      bit          r_en;
      bit          r_br;
      bit          r_ack;
      logic [31:0] r_tgt;
      r_en  = ($urandom_range(0, 9) < 8);
      r_br  = ($urandom_range(0, 9) == 0);
      r_ack = ($urandom_range(0, 9) < 4);
      r_tgt = bases[$urandom_range(0, 4)] + 32'($urandom_range(0, 63));
      cycle(r_en, r_br, r_tgt, r_ack);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
